// File: rtl/operand_entry.sv
// Operand entry: synchronises the raw switches and buttons, debounces each button,
// and applies clr/load/neg actions to a signed 8-bit operand with a one-cycle strobe.
// Build option: define OPERAND_SAT_EN to saturate -(-128) to +127; otherwise it wraps.
module operand_entry #(
  parameter int DB_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        sw,
  input  logic              btn_load,
  input  logic              btn_neg,
  input  logic              btn_clr,
  output logic signed [7:0] dout,
  output logic              valid,
  output logic              ovf
);

  // The counter never holds more than DB_CYCLES-1 before it flips and clears.
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  localparam int LOAD = 0;
  localparam int NEG  = 1;
  localparam int CLR  = 2;

  logic [7:0]    sw_s1, sw_s2;
  logic [2:0]    btn_s1, btn_s2;
  logic [2:0]    db, db_q;
  logic [CW-1:0] cnt [3];

  logic [2:0]        rise;
  logic signed [7:0] dout_n;
  logic              valid_n, ovf_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      db     <= '0;
      db_q   <= '0;
      // NOTE: the counter array is reset explicitly so a reset mid-debounce
      // discards the partial count; it is three registers, not a RAM.
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      dout   <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= {btn_clr, btn_neg, btn_load};
      btn_s2 <= btn_s1;
      db_q   <= db;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      dout  <= dout_n;
      valid <= valid_n;
      ovf   <= ovf_n;
    end
  end

  assign rise = db & ~db_q;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    dout_n  = dout;
    valid_n = 1'b0;
    ovf_n   = 1'b0;
    if (rise[CLR]) begin
      dout_n  = '0;
      valid_n = 1'b1;
    end else if (rise[LOAD]) begin
      dout_n  = sw_s2;
      valid_n = 1'b1;
    end else if (rise[NEG]) begin
      valid_n = 1'b1;
      if (dout == -8'sd128) begin
        ovf_n = 1'b1;
`ifdef OPERAND_SAT_EN
        dout_n = 8'sd127;
`else
        dout_n = dout;
`endif
      end else begin
        dout_n = -dout;
      end
    end
  end

endmodule
